// File: rtl/wb2ps_wfifo_seq.sv
// wb2ps_wfifo_seq: bus-master sequencer for the wb2ps write-FIFO bridge
// register port (0x030-0x03C). It runs one job per accept: it programs the
// address and area, starts the bridge, streams the words, ends the transfer,
// polls the end flag, clears it, then pulses done_p.
// Optional build macro WB2PS_SEQ_TIMEOUT_EN enables the poll timeout and err.
//
// state | meaning
// IDLE  | waiting for a job, job_ready=1
// WADR  | write 0x030 = destination address
// WARE  | write 0x034 = area in bytes
// STRT  | write 0x03C = 0x1 (start)
// DATA  | stream source words to 0x038
// ENDW  | write 0x03C = 0x2 (end)
// GAP   | bus idle for POLL_GAP cycles
// POLL  | read 0x03C, bit 8 = end flag
// CLR   | write 0x03C = 0x100 (clear flag)
// DONE  | one-cycle done_p
module wb2ps_wfifo_seq #(
  parameter int CNT_W    = 20,
  parameter int POLL_GAP = 4,
  parameter int TMO_CYC  = 65535
) (
  input  logic             cpuclk,
  input  logic             WSHRST,
  input  logic             job_valid,
  output logic             job_ready,
  input  logic [31:0]      job_addr,
  input  logic [CNT_W-1:0] job_words,
  input  logic             s_valid,
  input  logic [31:0]      s_data,
  output logic             s_ready,
  output logic [11:0]      m_addr,
  output logic [31:0]      m_wdata,
  output logic [3:0]       m_wstrb,
  output logic             m_valid,
  input  logic             m_ready,
  input  logic [31:0]      m_rdata,
  output logic             busy,
  output logic             done_p,
  output logic             err
);

  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP + 1) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_WADR, S_WARE, S_STRT, S_DATA,
    S_ENDW, S_GAP, S_POLL, S_CLR, S_DONE
  } state_t;

  state_t             state, state_nx;
  logic [31:0]        addr_q, area_q;
  logic [CNT_W-1:0]   rem;
  logic [GAP_W-1:0]   gap_cnt;
  logic               accept, tmo_hit, gap_load;
  logic               unused_rdata;

  assign unused_rdata = ^{m_rdata[31:9], m_rdata[7:0]};
  assign accept    = (state == S_IDLE) && job_valid;
  assign job_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);
  assign done_p    = (state == S_DONE);
  // reload the gap timer after the end write and after every poll that saw no flag
  assign gap_load  = ((state == S_ENDW) && m_ready) ||
                     ((state == S_POLL) && m_ready && !m_rdata[8] && !tmo_hit);

  // state register
  always_ff @(posedge cpuclk or posedge WSHRST) begin
    if (WSHRST) state <= S_IDLE;
    else        state <= state_nx;
  end

  // job registers, remaining word count and poll gap down-counter
  always_ff @(posedge cpuclk or posedge WSHRST) begin
    if (WSHRST) begin
      addr_q  <= '0;
      area_q  <= '0;
      rem     <= '0;
      gap_cnt <= '0;
    end else begin
      if (accept) begin
        addr_q <= job_addr;
        area_q <= 32'(job_words) << 2;
        rem    <= job_words;
      end else if ((state == S_DATA) && s_valid && m_ready) begin
        rem <= rem - CNT_W'(1);
      end
      if (gap_load)                              gap_cnt <= GAP_W'(POLL_GAP - 1);
      else if ((state == S_GAP) && (gap_cnt != 0)) gap_cnt <= gap_cnt - GAP_W'(1);
    end
  end

  // next state and bus outputs; outputs follow state so reset clears them at once
  always_comb begin
    state_nx = state;
    m_valid  = 1'b0;
    m_addr   = 12'h000;
    m_wdata  = 32'h0;
    m_wstrb  = 4'h0;
    s_ready  = 1'b0;
    case (state)
      S_IDLE: if (job_valid) state_nx = S_WADR;
      S_WADR: begin
        m_valid = 1'b1; m_addr = 12'h030; m_wdata = addr_q; m_wstrb = 4'hF;
        if (m_ready) state_nx = S_WARE;
      end
      S_WARE: begin
        m_valid = 1'b1; m_addr = 12'h034; m_wdata = area_q; m_wstrb = 4'hF;
        if (m_ready) state_nx = S_STRT;
      end
      S_STRT: begin
        m_valid = 1'b1; m_addr = 12'h03C; m_wdata = 32'h1; m_wstrb = 4'hF;
        if (m_ready) state_nx = (rem == '0) ? S_ENDW : S_DATA;
      end
      S_DATA: begin
        m_valid = s_valid; m_addr = 12'h038; m_wdata = s_data; m_wstrb = 4'hF;
        s_ready = s_valid && m_ready;
        if (s_valid && m_ready && (rem == CNT_W'(1))) state_nx = S_ENDW;
      end
      S_ENDW: begin
        m_valid = 1'b1; m_addr = 12'h03C; m_wdata = 32'h2; m_wstrb = 4'hF;
        if (m_ready) state_nx = S_GAP;
      end
      S_GAP: if (gap_cnt == '0) state_nx = S_POLL;
      S_POLL: begin
        m_valid = 1'b1; m_addr = 12'h03C;
        if (m_ready) state_nx = (m_rdata[8] || tmo_hit) ? S_CLR : S_GAP;
      end
      S_CLR: begin
        m_valid = 1'b1; m_addr = 12'h03C; m_wdata = 32'h100; m_wstrb = 4'hF;
        if (m_ready) state_nx = S_DONE;
      end
      S_DONE: state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

`ifdef WB2PS_SEQ_TIMEOUT_EN
  localparam int TMO_W = ($clog2(TMO_CYC + 1) > 16) ? $clog2(TMO_CYC + 1) : 16;
  logic [TMO_W-1:0] tmo_cnt;
  logic             err_q;

  assign tmo_hit = (tmo_cnt == TMO_W'(1));
  assign err     = err_q;

  // poll budget down-counter; the last flagless poll raises the sticky err
  always_ff @(posedge cpuclk or posedge WSHRST) begin
    if (WSHRST) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else if (accept) begin
      tmo_cnt <= TMO_W'(TMO_CYC);
      err_q   <= 1'b0;
    end else if ((state == S_POLL) && m_ready && !m_rdata[8]) begin
      if (tmo_hit)        err_q   <= 1'b1;
      if (tmo_cnt != '0)  tmo_cnt <= tmo_cnt - TMO_W'(1);
    end
  end
`else
  localparam int unused_tmo = TMO_CYC;
  assign tmo_hit = 1'b0;
  assign err     = 1'b0;
`endif

endmodule

// File: tb/tb_wb2ps_wfifo_seq.sv
// Testbench for wb2ps_wfifo_seq: randomized source/bridge behaviour checked
// every cycle against a transaction-list model of each job.
module tb_wb2ps_wfifo_seq;

  localparam int TMO = 3;
  localparam int GAP = 4;
`ifdef WB2PS_SEQ_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic        cpuclk = 1'b0;
  logic        WSHRST;
  logic        job_valid, job_ready;
  logic [31:0] job_addr;
  logic [19:0] job_words;
  logic        s_valid, s_ready;
  logic [31:0] s_data;
  logic [11:0] m_addr;
  logic [31:0] m_wdata, m_rdata;
  logic [3:0]  m_wstrb;
  logic        m_valid, m_ready;
  logic        busy, done_p, err;

  wb2ps_wfifo_seq #(.CNT_W(20), .POLL_GAP(GAP), .TMO_CYC(TMO)) dut (
    .cpuclk(cpuclk), .WSHRST(WSHRST),
    .job_valid(job_valid), .job_ready(job_ready), .job_addr(job_addr), .job_words(job_words),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .m_addr(m_addr), .m_wdata(m_wdata), .m_wstrb(m_wstrb), .m_valid(m_valid),
    .m_ready(m_ready), .m_rdata(m_rdata),
    .busy(busy), .done_p(done_p), .err(err)
  );

  always #5 cpuclk = ~cpuclk;

  typedef struct { logic [11:0] a; logic [31:0] d; logic [3:0] s; } xfer_t;
  xfer_t       exp_q[$];
  logic [11:0] obs_a[$];
  logic [31:0] obs_d[$];
  logic [31:0] src_q[$];
  int          src_idx, polls_done, flag_at, reads_seen;
  int          rdy_pct = 100, src_pct = 100, force_low = 0;
  bit          rd_seen, last_consumed, mon_en;
  bit          job_active, done_next, err_model, in_poll, prev_pend;
  int          idle_run;
  logic [11:0] prev_a;
  logic [31:0] prev_d;
  int          checks = 0, failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic abort(input string what);
    checks++;
    failures++;
    $display("FAIL %s: wait budget expired at %0t", what, $time);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench stopped");
  endtask

  function automatic int count_addr(input logic [11:0] a);
    int c = 0;
    foreach (obs_a[i]) if (obs_a[i] == a) c++;
    return c;
  endfunction

  // Source and bridge behaviour, driven just after each active edge
  initial begin
    s_valid = 0; s_data = 0; m_ready = 0; m_rdata = 0;
    forever begin
      @(posedge cpuclk); #1;
      if (WSHRST) begin
        s_valid = 0; m_ready = 0; rd_seen = 0; force_low = 0;
      end else begin
        if (!(s_valid && !last_consumed)) begin
          if (src_idx < src_q.size() && $urandom_range(0, 99) < src_pct) begin
            s_valid = 1; s_data = src_q[src_idx];
          end else begin
            s_valid = 0; s_data = $urandom;
          end
        end
        m_rdata = $urandom & ~32'h100;
        if (force_low > 0) begin
          m_ready = 0; force_low--;
        end else if (m_valid && m_wstrb == 4'h0) begin
          if (!rd_seen) begin
            m_ready = 0; rd_seen = 1;
          end else begin
            m_ready = ($urandom_range(0, 99) < rdy_pct);
            if (m_ready) rd_seen = 0;
          end
          if (polls_done + 1 >= flag_at) m_rdata = m_rdata | 32'h100;
        end else begin
          m_ready = ($urandom_range(0, 99) < rdy_pct);
        end
      end
    end
  end

  // Per-cycle compare against the job model
  always @(negedge cpuclk) begin
    if (WSHRST || !mon_en) begin
      prev_pend = 0; idle_run = 0; last_consumed = 0;
    end else begin
      chk("busy", busy, job_active);
      chk("job_ready", job_ready, !job_active);
      chk("done_p", done_p, done_next);
      chk("err", err, err_model);
      chk("s_ready", s_ready, m_valid && m_ready && m_addr == 12'h038 && m_wstrb == 4'hF);
      if (prev_pend) begin
        chk("hold_valid", m_valid, 1);
        chk("hold_addr", m_addr, prev_a);
        chk("hold_wdata", m_wdata, prev_d);
      end
      if (m_valid && !prev_pend && m_wstrb == 4'h0 && in_poll)
        chk("poll_gap", idle_run, GAP);
      if (!m_valid) idle_run++;
      if (m_valid && m_ready) begin
        if (exp_q.size() == 0) begin
          chk("extra_xfer_addr", m_addr, 12'hFFF);
        end else begin
          xfer_t e;
          e = exp_q.pop_front();
          chk("xfer_addr", m_addr, e.a);
          chk("xfer_strb", m_wstrb, e.s);
          if (e.s != 4'h0) chk("xfer_wdata", m_wdata, e.d);
        end
        obs_a.push_back(m_addr);
        obs_d.push_back(m_wstrb == 4'h0 ? 32'h0 : m_wdata);
        idle_run = 0;
        if (m_wstrb == 4'h0) begin
          polls_done++; reads_seen++;
          if (TMO_EN && !m_rdata[8] && polls_done == TMO) err_model = 1;
        end else if (m_addr == 12'h03C && m_wdata == 32'h2) in_poll = 1;
      end
      last_consumed = s_valid && s_ready;
      if (last_consumed) src_idx++;
      prev_pend = m_valid && !m_ready;
      prev_a = m_addr; prev_d = m_wdata;
      if (done_next) begin
        done_next = 0; job_active = 0;
      end
      if (m_valid && m_ready && m_wstrb == 4'hF && m_addr == 12'h03C && m_wdata == 32'h100) begin
        done_next = 1; in_poll = 0;
      end
      if (job_valid && !job_active) begin
        job_active = 1; err_model = 0;
      end
    end
  end

  // Build the expected bus transaction list for a job, then present it
  task automatic submit(input logic [31:0] a, input int words, input int fa);
    int n, nr;
    exp_q.delete(); obs_a.delete(); obs_d.delete(); src_q.delete();
    src_idx = 0; polls_done = 0; reads_seen = 0; flag_at = fa;
    exp_q.push_back('{12'h030, a, 4'hF});
    exp_q.push_back('{12'h034, 32'(words * 4), 4'hF});
    exp_q.push_back('{12'h03C, 32'h1, 4'hF});
    for (int i = 0; i < words; i++) begin
      logic [31:0] w;
      w = $urandom;
      src_q.push_back(w);
      exp_q.push_back('{12'h038, w, 4'hF});
    end
    exp_q.push_back('{12'h03C, 32'h2, 4'hF});
    nr = (TMO_EN && fa > TMO) ? TMO : fa;
    for (int i = 0; i < nr; i++) exp_q.push_back('{12'h03C, 32'h0, 4'h0});
    exp_q.push_back('{12'h03C, 32'h100, 4'hF});
    @(posedge cpuclk); #1;
    job_valid = 1; job_addr = a; job_words = 20'(words);
    n = 0;
    while (!job_active && n < 50) begin @(negedge cpuclk); #1; n++; end
    if (!job_active) abort("job_accept");
    @(posedge cpuclk); #1;
    job_valid = 0; job_addr = $urandom;
  endtask

  task automatic wait_job(output int cycles);
    cycles = 0;
    while (job_active && cycles < 4000) begin @(negedge cpuclk); #1; cycles++; end
    if (job_active) abort("job_done");
    chk("exp_queue_left", exp_q.size(), 0);
  endtask

  initial begin
    int cyc, n;
    WSHRST = 1; job_valid = 0; job_addr = 0; job_words = 0; mon_en = 0;
    #2;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_addr", m_addr, 0);
    chk("rst_busy", busy, 0);
    chk("rst_job_ready", job_ready, 1);
    chk("rst_err", err, 0);
    repeat (3) @(posedge cpuclk);
    #2 WSHRST = 0; mon_en = 1;

    // 1) four words, source always valid, bridge always ready
    rdy_pct = 100; src_pct = 100;
    submit(32'h0010_0000, 4, 1);
    wait_job(cyc);
    chk("t1_cycles_ge10", (cyc + 2) >= 10, 1);
    chk("t1_addr_word", obs_d[0], 32'h0010_0000);
    chk("t1_area", obs_d[1], 32'h10);
    chk("t1_data_writes", count_addr(12'h038), 4);
    chk("t1_xfers", obs_a.size(), 10);

    // 2) zero words: start directly followed by end
    repeat (3) @(posedge cpuclk);
    submit(32'h0000_0040, 0, 1);
    wait_job(cyc);
    chk("t2_data_writes", count_addr(12'h038), 0);
    chk("t2_start", obs_d[2], 32'h1);
    chk("t2_end", obs_d[3], 32'h2);

    // 3) sixteen words, toggling source, bridge stall mid-stream, busy job_valid ignored
    src_pct = 50;
    submit(32'h0020_0000, 16, 2);
    @(posedge cpuclk); #1; job_valid = 1; job_addr = 32'hDEAD_BEEF; job_words = 20'd7;
    repeat (2) @(posedge cpuclk); #1; job_valid = 0;
    n = 0;
    while (src_idx < 6 && n < 500) begin @(negedge cpuclk); n++; end
    if (src_idx < 6) abort("t3_midstream");
    force_low = 5;
    wait_job(cyc);
    chk("t3_data_writes", count_addr(12'h038), 16);

    // 4) flag appears only on the third poll
    src_pct = 100;
    submit(32'h0030_0000, 2, 3);
    wait_job(cyc);
    chk("t4_reads", reads_seen, 3);

    // 5) reset while streaming, then a clean job
    src_pct = 60;
    submit(32'h0040_0000, 16, 1);
    n = 0;
    while (src_idx < 3 && n < 500) begin @(negedge cpuclk); n++; end
    if (src_idx < 3) abort("t5_midstream");
    @(posedge cpuclk); #3;
    WSHRST = 1; mon_en = 0;
    #1;
    chk("t5_m_valid", m_valid, 0);
    chk("t5_m_addr", m_addr, 0);
    chk("t5_m_wdata", m_wdata, 0);
    chk("t5_m_wstrb", m_wstrb, 0);
    chk("t5_s_ready", s_ready, 0);
    chk("t5_busy", busy, 0);
    chk("t5_done_p", done_p, 0);
    exp_q.delete(); src_q.delete(); src_idx = 0;
    job_active = 0; done_next = 0; in_poll = 0; err_model = 0;
    repeat (2) @(posedge cpuclk);
    #2 WSHRST = 0; mon_en = 1;
    submit(32'h0050_0000, 3, 2);
    wait_job(cyc);
    chk("t5_first_addr", obs_a[0], 12'h030);
    chk("t5_data_writes", count_addr(12'h038), 3);

`ifdef WB2PS_SEQ_TIMEOUT_EN
    // 6) flag never set: timeout after TMO polls, err set then cleared by next accept
    submit(32'h0060_0000, 1, 1000);
    wait_job(cyc);
    chk("t6_reads", reads_seen, TMO);
    chk("t6_err", err, 1);
    submit(32'h0070_0000, 1, 1);
    chk("t6_err_cleared", err, 0);
    wait_job(cyc);
`endif

    // randomized jobs
    for (int j = 0; j < 8; j++) begin
      rdy_pct = $urandom_range(40, 100);
      src_pct = $urandom_range(40, 100);
      repeat ($urandom_range(0, 4)) @(posedge cpuclk);
      submit($urandom, $urandom_range(0, 24), $urandom_range(1, 3));
      wait_job(cyc);
    end

    repeat (3) @(posedge cpuclk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
